// File: rtl/pheap_level_pkg.sv
// Shared pipelined-heap types, sizes and key comparators used by every heap level.
package pheapTypes;

  localparam int LEVELS = 3;
  localparam int KEY_W  = 8;
  localparam int VAL_W  = 8;
  localparam int CAP_W  = LEVELS;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef struct packed {
    logic             active;
    logic [CAP_W-1:0] capacity;
    kv_t              kv;
  } entry_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LENQ  = 2'd1,
    LDEQ  = 2'd2,
    LREPL = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t levelOp;
    kv_t     kv;
  } opArray_t;

  typedef enum logic {
    DONE       = 1'b0,
    NEXT_LEVEL = 1'b1
  } done_t;

  localparam kv_t    KV_EMPTY    = '0;
  localparam entry_t ENTRY_EMPTY = '0;

  function automatic logic cmp_kv_gt(kv_t a, kv_t b);
    return a.key > b.key;
  endfunction

  // An active entry always outranks an inactive one; two inactive entries are equal.
  function automatic logic cmp_entry_entry_gt(entry_t a, entry_t b);
    if (a.active != b.active) return a.active;
    return a.active && cmp_kv_gt(a.kv, b.kv);
  endfunction

  function automatic logic [CAP_W-1:0] level_capacity(int level);
    return CAP_W'((1 << (LEVELS - level)) - 1);
  endfunction

endpackage

// File: rtl/pheap_level_if.sv
// Operation bus between adjacent heap levels: the opcode/kv word plus the target node index.
interface pheap_level_if import pheapTypes::*; #(
  parameter int IDX_W = 1
) ();

  opArray_t         op;
  logic [IDX_W-1:0] idx;

  modport master (output op, output idx);
  modport slave  (input  op, input  idx);

endinterface

// File: rtl/pheap_level.sv
// One level of a pipelined heap: holds 2**LEVEL nodes and forwards ops to the level below.
// Optional sticky protocol-error output is enabled by defining PHEAP_LEVEL_ERR_EN.
module pheap_level import pheapTypes::*; #(
  parameter  int LEVEL  = 0,
  localparam int IDX_W  = (LEVEL > 1) ? LEVEL : 1,
  localparam int PIDX_W = (LEVEL > 2) ? LEVEL - 1 : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  opArray_t          op_in,
  input  logic [IDX_W-1:0]  idx_in,
  output opArray_t          op_out,
  output logic [LEVEL:0]    idx_out,
  output logic [IDX_W-1:0]  chd_pidx,
  input  entry_t            chd_l,
  input  entry_t            chd_r,
  input  logic [PIDX_W-1:0] par_pidx,
  output entry_t            par_l,
  output entry_t            par_r,
  output done_t             status
`ifdef PHEAP_LEVEL_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int     NODES       = 2 ** LEVEL;
  localparam bit     BOTTOM      = (LEVEL == LEVELS - 1);
  localparam opArray_t OP_FREE   = '{levelOp: FREE, kv: KV_EMPTY};
  localparam entry_t RESET_ENTRY = '{active: 1'b0, capacity: level_capacity(LEVEL), kv: KV_EMPTY};

  entry_t           nodes_q [NODES];
  entry_t           nodeNext_d;
  opArray_t         opOut_q, opOut_d;
  logic [LEVEL:0]   idxOut_q, idxOut_d;
  logic [IDX_W-1:0] nodeIdx;
  entry_t           cur, kidL, kidR;
  logic             sel;
  logic             opValid;
  logic             unusedInputs;

  assign opValid      = (op_in.levelOp != FREE);
  assign nodeIdx      = (LEVEL == 0) ? '0 : idx_in;
  assign chd_pidx     = idx_in;
  assign kidL         = BOTTOM ? ENTRY_EMPTY : chd_l;
  assign kidR         = BOTTOM ? ENTRY_EMPTY : chd_r;
  assign unusedInputs = ^{chd_l, chd_r, par_pidx};

  always_comb begin
    cur = nodes_q[0];
    for (int n = 0; n < NODES; n++) begin
      if (n == int'(nodeIdx)) cur = nodes_q[n];
    end
  end

  generate
    if (LEVEL == 0) begin : g_root
      assign par_l = ENTRY_EMPTY;
      assign par_r = ENTRY_EMPTY;
    end else begin : g_par
      always_comb begin
        par_l = nodes_q[0];
        par_r = nodes_q[1];
        for (int n = 0; n < NODES / 2; n++) begin
          if (n == int'(par_pidx)) begin
            par_l = nodes_q[2*n];
            par_r = nodes_q[2*n+1];
          end
        end
      end
    end
  endgenerate

  // sel picks which child of the current node receives the forwarded op (0 = left).
  always_comb begin
    nodeNext_d = cur;
    opOut_d    = OP_FREE;
    sel        = 1'b0;
    case (op_in.levelOp)
      LENQ: begin
        if (cur.capacity != '0) nodeNext_d.capacity = cur.capacity - CAP_W'(1);
        if (!cur.active) begin
          nodeNext_d.active = 1'b1;
          nodeNext_d.kv     = op_in.kv;
        end else begin
          sel             = (kidR.capacity > kidL.capacity);
          opOut_d.levelOp = LENQ;
          if (cmp_kv_gt(op_in.kv, cur.kv)) begin
            nodeNext_d.kv = op_in.kv;
            opOut_d.kv    = cur.kv;
          end else begin
            opOut_d.kv    = op_in.kv;
          end
        end
      end
      LDEQ: begin
        nodeNext_d.capacity = cur.capacity + CAP_W'(1);
        if (!kidL.active && !kidR.active) begin
          nodeNext_d.active = 1'b0;
          nodeNext_d.kv     = KV_EMPTY;
        end else begin
          sel             = cmp_entry_entry_gt(kidR, kidL);
          nodeNext_d.kv   = sel ? kidR.kv : kidL.kv;
          opOut_d.levelOp = LDEQ;
        end
      end
      LREPL: begin
        if ((!kidL.active || !cmp_kv_gt(kidL.kv, op_in.kv)) &&
            (!kidR.active || !cmp_kv_gt(kidR.kv, op_in.kv))) begin
          nodeNext_d.kv = op_in.kv;
        end else begin
          sel             = cmp_entry_entry_gt(kidR, kidL);
          nodeNext_d.kv   = sel ? kidR.kv : kidL.kv;
          opOut_d.levelOp = LREPL;
          opOut_d.kv      = op_in.kv;
        end
      end
      default: ;
    endcase
    if (BOTTOM) opOut_d = OP_FREE;
    idxOut_d = (LEVEL+1)'({idx_in, sel});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) nodes_q[n] <= RESET_ENTRY;
      opOut_q  <= OP_FREE;
      idxOut_q <= '0;
    end else begin
      for (int n = 0; n < NODES; n++) begin
        if (opValid && n == int'(nodeIdx)) nodes_q[n] <= nodeNext_d;
      end
      opOut_q  <= opOut_d;
      idxOut_q <= idxOut_d;
    end
  end

  assign op_out  = opOut_q;
  assign idx_out = idxOut_q;
  assign status  = (opOut_q.levelOp != FREE) ? NEXT_LEVEL : DONE;

`ifdef PHEAP_LEVEL_ERR_EN
  logic err_q, prevValid_q, protoErr;

  // Overfull enqueue, dequeue from an empty node, or ops closer than two cycles apart.
  assign protoErr = opValid &&
                    ((op_in.levelOp == LENQ && cur.capacity == '0) ||
                     (op_in.levelOp == LDEQ && !cur.active) ||
                     prevValid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      prevValid_q <= 1'b0;
    end else begin
      prevValid_q <= opValid;
      err_q       <= err_q | protoErr;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/pheap_level.md
PHEAP_LEVEL -- requirements
Module: pheap_level

Interface
- REQ-001 SHALL have parameter LEVEL, default 0, meaning heap level index (0 = root, LEVELS-1 = bottom).
- REQ-002 SHALL define IDX_W = max(LEVEL,1) and NODES = 2**LEVEL.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
- REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port op_in, input, opArray_t, the operation from level LEVEL-1; valid when levelOp != FREE.
- REQ-006 SHALL have port idx_in, input, IDX_W, the target node within this level.
- REQ-007 SHALL have port op_out, output, opArray_t, the registered operation to level LEVEL+1.
- REQ-008 SHALL have port idx_out, output, LEVEL+1, the registered child index {idx_in, sel}.
- REQ-009 SHALL have port chd_pidx, output, IDX_W, the parent index whose children are read from level LEVEL+1; driven by idx_in.
- REQ-010 SHALL have ports chd_l and chd_r, input, entry_t each, the children 2*chd_pidx and 2*chd_pidx+1 from level LEVEL+1, read combinationally.
- REQ-011 SHALL have port par_pidx, input, max(LEVEL-1,1), the read request from level LEVEL-1.
- REQ-012 SHALL have ports par_l and par_r, output, entry_t each, the combinational reads of nodes 2*par_pidx and 2*par_pidx+1.
- REQ-013 SHALL have port status, output, done_t: NEXT_LEVEL when op_out is non-FREE, else DONE.
- REQ-014 SHALL have port err, output, 1, a sticky protocol error; exists only under PHEAP_LEVEL_ERR_EN.

Function
- REQ-015 SHALL hold NODES entry_t registers; node capacity means free slots in its subtree.
- REQ-016 SHALL process op_in in its arrival cycle, update the node at the clock edge, and register op_out/idx_out (latency 1).
- REQ-017 SHALL emit FREE (kv = KV_EMPTY) in every cycle with no op to forward.
- REQ-018 LENQ: capacity-1; if node inactive then store kv, set active, emit FREE.
- REQ-019 LENQ on an active node: store the greater of kv and node.kv using cmp_kv_gt; emit the lesser as LENQ to the child with larger capacity (left on tie).
- REQ-020 LDEQ: capacity+1; if both children are inactive then set the node inactive, emit FREE.
- REQ-021 LDEQ otherwise: copy the greater child kv using cmp_entry_entry_gt (left on tie); emit LDEQ to that child.
- REQ-022 LREPL: capacity unchanged; if kv is not less than either active child then store kv, emit FREE.
- REQ-023 LREPL otherwise: store the greater child kv; emit LREPL carrying the input kv to that child.
- REQ-024 Bottom level (LEVEL == LEVELS-1): SHALL treat chd_l/chd_r as ENTRY_EMPTY, and op_out SHALL always be FREE.
- REQ-025 Upstream SHALL space ops at least 2 cycles apart; back-to-back input is undefined, and is flagged under PHEAP_LEVEL_ERR_EN.

Reset
- REQ-026 On rst_n low, every node SHALL become ENTRY_EMPTY with capacity = 2**(LEVELS-LEVEL)-1; op_out = FREE/KV_EMPTY, idx_out = 0, status = DONE, err = 0.
- REQ-027 Reset mid-operation SHALL discard any in-flight op without emitting it.

Configuration
- REQ-028 Macro PHEAP_LEVEL_ERR_EN: when defined, err SHALL set on LENQ with capacity 0, LDEQ on an inactive node, or two non-FREE ops in consecutive cycles, and clear only on reset.
- REQ-029 Without PHEAP_LEVEL_ERR_EN, the err port and checks SHALL be absent and the node update rules unchanged.

Structure
- REQ-030 entry_t, opArray_t, done_t, opcode_t, ENTRY_EMPTY, LEVELS and the compare functions SHALL come from pheapTypes; no new shared types.
- REQ-031 The block SHALL be one module with no sub-module; a parent generates LEVELS instances chained op_out->op_in and chd*->par*.

Verification (LEVELS=3, LEVEL=1, keys only)
- REQ-032 After reset: par_l/par_r show capacity 3, inactive; op_out = FREE.
- REQ-033 LENQ key 5 at idx 0: node0 = 5 active with capacity 2; op_out FREE one cycle later.
- REQ-034 With node0 = 5, LENQ key 9 at idx 0 and children empty: node0 = 9 with capacity 1; op_out = LENQ 5, idx_out = 0.
- REQ-035 With node0 = 9 and children 4 and 7: LDEQ at idx 0 gives node0 = 7, op_out = LDEQ, idx_out = 1.
- REQ-036 With node0 = 9 and children 4 and 7: LREPL key 2 at idx 0 gives node0 = 7, op_out = LREPL key 2, idx_out = 1; the same with key 8 gives node0 = 8, op_out = FREE.
- REQ-037 With ERR_EN and node capacity 0: LENQ sets err = 1, which persists until rst_n is asserted.
